// File: rtl/seven_seg_decoder_mon_if.sv
// rtl/seven_seg_decoder_mon_if.sv - segment-line and decode-result bundle for the 7-segment monitor
//
// Purpose: groups the sampled segment/decimal-point lines with the decoded
// results, step pulses and dwell measurement of seven_seg_decoder_mon.
// Ports (signals):
//   seg_in[6:0]   segment lines, [6]=A ... [0]=G, active-high
//   dp_in         decimal point line
//   digit[3:0]    last accepted valid hex value
//   digit_valid   accepted pattern is a hex glyph
//   blank         accepted pattern is all-off
//   invalid       accepted pattern is neither glyph nor blank
//   dp_out        dp_in delayed one cycle
//   new_digit     pulse on each accepted pattern change
//   step_up       pulse: valid digit advanced by one
//   step_down     pulse: valid digit retreated by one
//   step_err      pulse: valid->valid change that is not +/-1
//   turnaround    pulse: step direction reversed
//   dir_down      level: direction of last +/-1 step
//   dwell_count   cycles between the last two accepted changes
//   dwell_valid   dwell_count holds a real measurement
// Modports: master drives the segment lines, slave is the monitor.

interface seven_seg_decoder_mon_if #(
   parameter int DWELL_W = 27
);
   logic [6:0]         seg_in;
   logic               dp_in;
   logic [3:0]         digit;
   logic               digit_valid;
   logic               blank;
   logic               invalid;
   logic               dp_out;
   logic               new_digit;
   logic               step_up;
   logic               step_down;
   logic               step_err;
   logic               turnaround;
   logic               dir_down;
   logic [DWELL_W-1:0] dwell_count;
   logic               dwell_valid;

   modport master (
      output seg_in, dp_in,
      input  digit, digit_valid, blank, invalid, dp_out, new_digit,
      input  step_up, step_down, step_err, turnaround, dir_down,
      input  dwell_count, dwell_valid
   );

   modport slave (
      input  seg_in, dp_in,
      output digit, digit_valid, blank, invalid, dp_out, new_digit,
      output step_up, step_down, step_err, turnaround, dir_down,
      output dwell_count, dwell_valid
   );
endinterface

// File: rtl/seven_seg_decoder_mon.sv
// rtl/seven_seg_decoder_mon.sv - 7-segment pattern monitor: debounce, decode, step and dwell tracking
//
// Purpose: samples the segment lines of a 7-segment driver, accepts a pattern
// once it has been stable for STABLE_CYCLES samples, decodes it to a hex
// digit / blank / invalid class, classifies valid->valid changes as +1, -1
// or error steps, and measures the dwell time between accepted changes.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous reset, active-low
//   bus   seven_seg_decoder_mon_if.slave (segment inputs and all results)

module seven_seg_decoder_mon #(
   parameter int STABLE_CYCLES = 4,
   parameter int DWELL_W       = 27
) (
   input  logic                   clk,
   input  logic                   rst,
   seven_seg_decoder_mon_if.slave bus
);

   localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BLANK   = 2'd0,
      ST_VALID   = 2'd1,
      ST_INVALID = 2'd2
   } cls_t;

   // Glyph lookup: returns {hit, value}.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = {1'b1, 4'h0};
         7'h30:   r = {1'b1, 4'h1};
         7'h6D:   r = {1'b1, 4'h2};
         7'h79:   r = {1'b1, 4'h3};
         7'h33:   r = {1'b1, 4'h4};
         7'h5B:   r = {1'b1, 4'h5};
         7'h5F:   r = {1'b1, 4'h6};
         7'h70:   r = {1'b1, 4'h7};
         7'h7F:   r = {1'b1, 4'h8};
         7'h73:   r = {1'b1, 4'h9};
         7'h77:   r = {1'b1, 4'hA};
         7'h1F:   r = {1'b1, 4'hB};
         7'h4E:   r = {1'b1, 4'hC};
         7'h3D:   r = {1'b1, 4'hD};
         7'h4F:   r = {1'b1, 4'hE};
         7'h47:   r = {1'b1, 4'hF};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   // Input stage
   logic [6:0]         seg_r;
   logic [SC_W-1:0]    stab_cnt;
   logic [6:0]         acc;
   logic               accept;

   // Decode
   logic [4:0]         dec;
   logic               dec_hit;
   logic [3:0]         dec_val;
   cls_t               seg_class;

   // Class FSM
   cls_t               state_q;
   cls_t               state_d;
   logic               digit_valid_o;
   logic               blank_o;
   logic               invalid_o;

   // Step / dwell state
   logic [3:0]         digit_q;
   logic               have_prev;
   logic               seen_accept;
   logic               dir_down_q;
   logic               is_up;
   logic               is_down;
   logic               new_digit_q;
   logic               step_up_q;
   logic               step_down_q;
   logic               step_err_q;
   logic               turnaround_q;
   logic               dp_q;
   logic [DWELL_W-1:0] timer;
   logic [DWELL_W-1:0] dwell_q;
   logic               dwell_valid_q;

   // A pattern is stable once stab_cnt saturates: seg_r then equals the
   // last STABLE_CYCLES samples of seg_in.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_r    <= 7'h00;
         stab_cnt <= '0;
      end else begin
         seg_r <= bus.seg_in;
         if (bus.seg_in == seg_r)
            stab_cnt <= (stab_cnt == SC_MAX) ? stab_cnt : stab_cnt + 1'b1;
         else
            stab_cnt <= '0;
      end
   end

   assign accept = (stab_cnt == SC_MAX) && (seg_r != acc);

   always_comb begin
      dec     = decode(seg_r);
      dec_hit = dec[4];
      dec_val = dec[3:0];
      if (dec_hit)
         seg_class = ST_VALID;
      else if (seg_r == 7'h00)
         seg_class = ST_BLANK;
      else
         seg_class = ST_INVALID;
   end

   // Class FSM: state register
   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= ST_BLANK;
      else
         state_q <= state_d;
   end

   // Class FSM: next state
   always_comb begin
      state_d = state_q;
      if (accept)
         state_d = seg_class;
   end

   // Class FSM: outputs (exactly one of the three is high)
   always_comb begin
      digit_valid_o = 1'b0;
      blank_o       = 1'b0;
      invalid_o     = 1'b0;
      case (state_q)
         ST_VALID:   digit_valid_o = 1'b1;
         ST_INVALID: invalid_o     = 1'b1;
         default:    blank_o       = 1'b1;
      endcase
   end

   // Step comparison in 5 bits so F->0 and 0->F never look like +/-1.
   always_comb begin
      is_up   = ({1'b0, dec_val} == ({1'b0, digit_q} + 5'd1));
      is_down = (({1'b0, dec_val} + 5'd1) == {1'b0, digit_q});
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc           <= 7'h00;
         digit_q       <= 4'h0;
         have_prev     <= 1'b0;
         seen_accept   <= 1'b0;
         dir_down_q    <= 1'b0;
         new_digit_q   <= 1'b0;
         step_up_q     <= 1'b0;
         step_down_q   <= 1'b0;
         step_err_q    <= 1'b0;
         turnaround_q  <= 1'b0;
         dp_q          <= 1'b0;
         timer         <= '0;
         dwell_q       <= '0;
         dwell_valid_q <= 1'b0;
      end else begin
         new_digit_q  <= 1'b0;
         step_up_q    <= 1'b0;
         step_down_q  <= 1'b0;
         step_err_q   <= 1'b0;
         turnaround_q <= 1'b0;
         dp_q         <= bus.dp_in;
         timer        <= &timer ? timer : timer + 1'b1;
         if (accept) begin
            acc         <= seg_r;
            new_digit_q <= 1'b1;
            timer       <= '0;
            // timer was cleared on the previous accept edge, so the edge
            // count between the two accepts is one more than its value.
            if (seen_accept) begin
               dwell_q       <= &timer ? timer : timer + 1'b1;
               dwell_valid_q <= 1'b1;
            end
            seen_accept <= 1'b1;
            if (seg_class == ST_VALID) begin
               digit_q   <= dec_val;
               have_prev <= 1'b1;
               if (have_prev) begin
                  if (is_up) begin
                     step_up_q    <= 1'b1;
                     turnaround_q <= dir_down_q;
                     dir_down_q   <= 1'b0;
                  end else if (is_down) begin
                     step_down_q  <= 1'b1;
                     turnaround_q <= ~dir_down_q;
                     dir_down_q   <= 1'b1;
                  end else begin
                     step_err_q <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.digit       = digit_q;
   assign bus.digit_valid = digit_valid_o;
   assign bus.blank       = blank_o;
   assign bus.invalid     = invalid_o;
   assign bus.dp_out      = dp_q;
   assign bus.new_digit   = new_digit_q;
   assign bus.step_up     = step_up_q;
   assign bus.step_down   = step_down_q;
   assign bus.step_err    = step_err_q;
   assign bus.turnaround  = turnaround_q;
   assign bus.dir_down    = dir_down_q;
   assign bus.dwell_count = dwell_q;
   assign bus.dwell_valid = dwell_valid_q;

endmodule

// File: tb/tb_seven_seg_decoder_mon.sv
// tb/tb_seven_seg_decoder_mon.sv - self-checking bench for seven_seg_decoder_mon

module tb_seven_seg_decoder_mon;

   localparam int S  = 4;
   localparam int DW = 27;
   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seven_seg_decoder_mon_if #(.DWELL_W(DW)) bus ();

   seven_seg_decoder_mon #(.STABLE_CYCLES(S), .DWELL_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [6:0]  hist [$];
   logic [6:0]  m_acc;
   int          m_digit;
   int          m_class;        // 0 blank, 1 valid, 2 invalid
   bit          m_have_prev, m_seen, m_dir, m_dp;
   bit          m_new, m_up, m_dn, m_err, m_turn, m_dv;
   longint      m_dwell, cyc, last_acc;

   // Observed pulse counters for directed windows
   int cnt_new, cnt_up, cnt_dn, cnt_err, cnt_turn;

   function automatic int glyph_idx(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (GLYPH[i] == p) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [6:0] s, input logic d, input logic r);
      bit stable;
      int idx;
      cyc++;
      if (!r) begin
         hist.delete();
         hist.push_back(7'h00);
         m_acc = 7'h00; m_digit = 0; m_class = 0;
         m_have_prev = 0; m_seen = 0; m_dir = 0; m_dp = 0;
         m_new = 0; m_up = 0; m_dn = 0; m_err = 0; m_turn = 0;
         m_dwell = 0; m_dv = 0; last_acc = cyc;
         return;
      end
      m_new = 0; m_up = 0; m_dn = 0; m_err = 0; m_turn = 0;
      stable = (hist.size() >= S);
      if (stable)
         for (int i = hist.size() - S; i < hist.size(); i++)
            if (hist[i] != hist[hist.size()-1]) stable = 0;
      if (stable && hist[hist.size()-1] != m_acc) begin
         m_acc = hist[hist.size()-1];
         m_new = 1;
         if (m_seen) begin
            m_dwell = cyc - last_acc;
            if (m_dwell > (64'd1 << DW) - 1) m_dwell = (64'd1 << DW) - 1;
            m_dv = 1;
         end
         m_seen = 1;
         last_acc = cyc;
         idx = glyph_idx(m_acc);
         if (idx >= 0) begin
            if (m_have_prev) begin
               if (idx == m_digit + 1) begin
                  m_up = 1; m_turn = m_dir; m_dir = 0;
               end else if (idx == m_digit - 1) begin
                  m_dn = 1; m_turn = !m_dir; m_dir = 1;
               end else begin
                  m_err = 1;
               end
            end
            m_digit = idx; m_have_prev = 1; m_class = 1;
         end else begin
            m_class = (m_acc == 7'h00) ? 0 : 2;
         end
      end
      m_dp = d;
      hist.push_back(s);
      while (hist.size() > S) void'(hist.pop_front());
   endtask

   task automatic check_all();
      chk("digit",       32'(bus.digit),       32'(m_digit));
      chk("digit_valid", 32'(bus.digit_valid), 32'(m_class == 1));
      chk("blank",       32'(bus.blank),       32'(m_class == 0));
      chk("invalid",     32'(bus.invalid),     32'(m_class == 2));
      chk("dp_out",      32'(bus.dp_out),      32'(m_dp));
      chk("new_digit",   32'(bus.new_digit),   32'(m_new));
      chk("step_up",     32'(bus.step_up),     32'(m_up));
      chk("step_down",   32'(bus.step_down),   32'(m_dn));
      chk("step_err",    32'(bus.step_err),    32'(m_err));
      chk("turnaround",  32'(bus.turnaround),  32'(m_turn));
      chk("dir_down",    32'(bus.dir_down),    32'(m_dir));
      chk("dwell_count", 32'(bus.dwell_count), 32'(m_dwell));
      chk("dwell_valid", 32'(bus.dwell_valid), 32'(m_dv));
   endtask

   task automatic tick(input logic [6:0] s, input logic r);
      logic d;
      d = 1'($urandom);
      @(negedge clk);
      bus.seg_in = s;
      bus.dp_in  = d;
      rst        = r;
      @(posedge clk);
      model_edge(s, d, r);
      #1;
      check_all();
      cnt_new  += int'(bus.new_digit);
      cnt_up   += int'(bus.step_up);
      cnt_dn   += int'(bus.step_down);
      cnt_err  += int'(bus.step_err);
      cnt_turn += int'(bus.turnaround);
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      repeat (n) tick(s, 1'b1);
   endtask

   task automatic zero_counts();
      cnt_new = 0; cnt_up = 0; cnt_dn = 0; cnt_err = 0; cnt_turn = 0;
   endtask

   int lat;
   int r;
   logic [6:0] p;

   initial begin
      bus.seg_in = 7'h00;
      bus.dp_in  = 1'b0;
      rst        = 1'b0;
      cyc        = 0;

      // 1: reset and idle blank
      tick(7'h00, 1'b0);
      tick(7'h00, 1'b0);
      chk("reset_blank", 32'(bus.blank), 32'd1);
      chk("reset_dp",    32'(bus.dp_out), 32'd0);
      zero_counts();
      hold(7'h00, 100);
      chk("idle_new_cnt", 32'(cnt_new), 32'd0);
      chk("idle_blank",   32'(bus.blank), 32'd1);

      // 2: 0 then 1, latency of step_up
      hold(7'h7E, 20);
      chk("digit_0", 32'(bus.digit), 32'h0);
      zero_counts();
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(7'h30, 1'b1);
         if (bus.step_up && lat < 0) lat = i;
      end
      chk("step_up_latency", 32'(lat), 32'd5);
      chk("step_up_once",    32'(cnt_up), 32'd1);
      chk("digit_1",         32'(bus.digit), 32'h1);
      chk("dir_up",          32'(bus.dir_down), 32'd0);

      // 3: glitches
      zero_counts();
      repeat (3) begin
         hold(7'h7F, 3);
         hold(7'h30, 10);
      end
      chk("glitch3_new_cnt", 32'(cnt_new), 32'd0);
      zero_counts();
      hold(7'h7F, 4);
      hold(7'h30, 15);
      chk("glitch4_new_cnt", 32'(cnt_new), 32'd2);

      // 4: ramp 0..F..0 after a fresh reset
      tick(7'h00, 1'b0);
      zero_counts();
      for (int g = 0; g < 16; g++) hold(GLYPH[g], 10);
      for (int g = 14; g >= 0; g--) hold(GLYPH[g], 10);
      chk("ramp_up_cnt",   32'(cnt_up),   32'd15);
      chk("ramp_dn_cnt",   32'(cnt_dn),   32'd15);
      chk("ramp_turn_cnt", 32'(cnt_turn), 32'd1);
      chk("ramp_err_cnt",  32'(cnt_err),  32'd0);
      chk("ramp_dwell",    32'(bus.dwell_count), 32'd10);

      // 5: wrap is an error, then invalid pattern
      hold(7'h47, 20);
      zero_counts();
      hold(7'h7E, 20);
      chk("wrap_err_cnt", 32'(cnt_err), 32'd1);
      chk("wrap_up_cnt",  32'(cnt_up),  32'd0);
      hold(7'h01, 20);
      chk("inv_invalid", 32'(bus.invalid),     32'd1);
      chk("inv_digit",   32'(bus.digit),       32'h0);
      chk("inv_dvalid",  32'(bus.digit_valid), 32'd0);

      // 6: reset mid-ramp at digit 5
      for (int g = 0; g <= 5; g++) hold(GLYPH[g], 10);
      tick(7'h5B, 1'b0);
      chk("mid_rst_digit",  32'(bus.digit),       32'h0);
      chk("mid_rst_blank",  32'(bus.blank),       32'd1);
      chk("mid_rst_dir",    32'(bus.dir_down),    32'd0);
      chk("mid_rst_dwellv", 32'(bus.dwell_valid), 32'd0);
      zero_counts();
      hold(7'h5B, 10);
      chk("post_rst_steps", 32'(cnt_up + cnt_dn + cnt_err), 32'd0);
      chk("post_rst_dwellv", 32'(bus.dwell_valid), 32'd0);
      hold(7'h5F, 10);
      chk("post_rst_dwellv2", 32'(bus.dwell_valid), 32'd1);

      // Randomized patterns, hold lengths and occasional resets
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      p = GLYPH[$urandom_range(0, 15)];
         else if (r < 75) p = 7'h00;
         else             p = 7'($urandom);
         if ($urandom_range(0, 49) == 0) tick(p, 1'b0);
         hold(p, $urandom_range(1, 12));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
